// File: rtl/lsq_dcache_arbiter_if.sv
// lsq_dcache_arbiter_if: store-retire, load-request, D-cache request/response and
// load-response signals of the LSQ/D-cache arbiter. master = arbiter side.
interface lsq_dcache_arbiter_if #(
  parameter int NUM_SUPER = 2,
  parameter int ADDR_W    = 61,
  parameter int LQ_IDX_W  = 3
);
  logic [NUM_SUPER-1:0]             st_wr_en;
  logic [NUM_SUPER-1:0][ADDR_W-1:0] st_addr;
  logic [NUM_SUPER-1:0][63:0]       st_value;
  logic                             csb_ready;
  logic                             csb_empty;

  logic                             ld_req_valid;
  logic [ADDR_W-1:0]                ld_req_addr;
  logic [LQ_IDX_W-1:0]              ld_req_lq_idx;
  logic                             ld_req_ready;
  logic                             rollback_en;

  logic                             dc_req_valid;
  logic                             dc_req_wr;
  logic [ADDR_W-1:0]                dc_req_addr;
  logic [63:0]                      dc_req_value;
  logic                             dc_req_ready;
  logic                             dc_rsp_valid;
  logic [63:0]                      dc_rsp_data;

  logic                             ld_rsp_valid;
  logic [LQ_IDX_W-1:0]              ld_rsp_lq_idx;
  logic [63:0]                      ld_rsp_data;

  modport master (
    input  st_wr_en, st_addr, st_value,
    input  ld_req_valid, ld_req_addr, ld_req_lq_idx, rollback_en,
    input  dc_req_ready, dc_rsp_valid, dc_rsp_data,
    output csb_ready, csb_empty, ld_req_ready,
    output dc_req_valid, dc_req_wr, dc_req_addr, dc_req_value,
    output ld_rsp_valid, ld_rsp_lq_idx, ld_rsp_data
  );

  modport slave (
    output st_wr_en, st_addr, st_value,
    output ld_req_valid, ld_req_addr, ld_req_lq_idx, rollback_en,
    output dc_req_ready, dc_rsp_valid, dc_rsp_data,
    input  csb_ready, csb_empty, ld_req_ready,
    input  dc_req_valid, dc_req_wr, dc_req_addr, dc_req_value,
    input  ld_rsp_valid, ld_rsp_lq_idx, ld_rsp_data
  );
endinterface

// File: rtl/lsq_dcache_arbiter.sv
// lsq_dcache_arbiter: shares the D-cache port between committed stores (in-order CSB drain)
// and one outstanding load. Define LSQ_ARB_FWD_EN to forward same-address loads from the CSB.
module lsq_dcache_arbiter #(
  parameter int NUM_SUPER    = 2,
  parameter int CSB_DEPTH    = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 61,
  parameter int LQ_IDX_W     = 3
) (
  input logic                  clock,
  input logic                  reset,
  lsq_dcache_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(CSB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LD_WAIT   = 2'd1,
    LD_SQUASH = 2'd2,
    LD_FWD    = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0]               csb_addr  [CSB_DEPTH];
  logic [63:0]                     csb_value [CSB_DEPTH];
  logic [PTR_W-1:0]                head, tail;
  logic [CNT_W-1:0]                count, count_next, enq_cnt;
  logic [STV_W-1:0]                starve_cnt;
  logic                            csb_ready_q, csb_empty_q;
  logic [NUM_SUPER-1:0]            enq_fire;
  logic [NUM_SUPER-1:0][PTR_W-1:0] enq_ptr;

  logic                            conflict;
  logic [63:0]                     fwd_value;
  logic                            load_elig, store_elig, store_win, load_win;
  logic                            store_hs, load_hs, fwd_accept;
  logic [LQ_IDX_W-1:0]             tag_q;
  logic [63:0]                     fwd_data_q;
  logic                            ld_rsp_valid;
  logic [63:0]                     ld_rsp_data;

  // Enqueue: set slots take consecutive tail positions in slot order.
  always_comb begin
    enq_cnt  = '0;
    enq_fire = '0;
    enq_ptr  = '0;
    for (int s = 0; s < NUM_SUPER; s++) begin
      enq_ptr[s]  = tail + enq_cnt[PTR_W-1:0];
      enq_fire[s] = csb_ready_q & bus.st_wr_en[s];
      if (enq_fire[s]) enq_cnt = enq_cnt + CNT_W'(1);
    end
  end

  // Scan oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    conflict  = 1'b0;
    fwd_value = '0;
    for (int i = 0; i < CSB_DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (csb_addr[head + PTR_W'(i)] == bus.ld_req_addr)) begin
        conflict  = 1'b1;
        fwd_value = csb_value[head + PTR_W'(i)];
      end
    end
  end

  assign store_elig = (count != '0);
  assign load_elig  = (state == IDLE) & bus.ld_req_valid & ~conflict;
  assign store_win  = store_elig & ((count == CNT_W'(CSB_DEPTH)) | ~load_elig |
                                    (starve_cnt >= STV_W'(STARVE_LIMIT)));
  assign load_win   = load_elig & ~store_win;
  assign store_hs   = store_win & bus.dc_req_ready;
  assign load_hs    = load_win & bus.dc_req_ready;

`ifdef LSQ_ARB_FWD_EN
  assign fwd_accept = (state == IDLE) & bus.ld_req_valid & conflict;
`else
  assign fwd_accept = 1'b0;
`endif

  assign count_next = count + enq_cnt - {{(CNT_W-1){1'b0}}, store_hs};

  assign bus.csb_ready     = csb_ready_q;
  assign bus.csb_empty     = csb_empty_q;
  assign bus.ld_req_ready  = load_hs | fwd_accept;
  assign bus.dc_req_valid  = store_win | load_win;
  assign bus.dc_req_wr     = store_win;
  assign bus.dc_req_addr   = store_win ? csb_addr[head] :
                             (load_win ? bus.ld_req_addr : '0);
  assign bus.dc_req_value  = store_win ? csb_value[head] : '0;
  assign bus.ld_rsp_valid  = ld_rsp_valid;
  assign bus.ld_rsp_lq_idx = ld_rsp_valid ? tag_q : '0;
  assign bus.ld_rsp_data   = ld_rsp_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      starve_cnt  <= '0;
      csb_ready_q <= 1'b1;
      csb_empty_q <= 1'b1;
    end else begin
      tail        <= tail + enq_cnt[PTR_W-1:0];
      if (store_hs) head <= head + PTR_W'(1);
      count       <= count_next;
      csb_ready_q <= (CNT_W'(CSB_DEPTH) - count_next) >= CNT_W'(NUM_SUPER);
      csb_empty_q <= (count_next == '0);
      if (store_hs)
        starve_cnt <= '0;
      else if (store_elig && (starve_cnt < STV_W'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // Payload storage carries no reset; validity comes from count and the FSM.
  always_ff @(posedge clock) begin
    for (int s = 0; s < NUM_SUPER; s++) begin
      if (enq_fire[s]) begin
        csb_addr[enq_ptr[s]]  <= bus.st_addr[s];
        csb_value[enq_ptr[s]] <= bus.st_value[s];
      end
    end
    if (load_hs | fwd_accept) tag_q      <= bus.ld_req_lq_idx;
    if (fwd_accept)           fwd_data_q <= fwd_value;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    ld_rsp_valid = 1'b0;
    ld_rsp_data  = '0;
    case (state)
      IDLE: begin
        if (fwd_accept)   state_next = LD_FWD;
        else if (load_hs) state_next = LD_WAIT;
      end
      LD_WAIT: begin
        if (bus.dc_rsp_valid) begin
          ld_rsp_valid = 1'b1;
          ld_rsp_data  = bus.dc_rsp_data;
          state_next   = IDLE;
        end else if (bus.rollback_en) begin
          state_next = LD_SQUASH;
        end
      end
      LD_SQUASH: begin
        if (bus.dc_rsp_valid) state_next = IDLE;
      end
      LD_FWD: begin
        ld_rsp_valid = ~bus.rollback_en;
        ld_rsp_data  = bus.rollback_en ? 64'd0 : fwd_data_q;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lsq_dcache_arbiter.sv
// tb_lsq_dcache_arbiter: directed vectors for CSB drain/fill, starvation, load squash,
// same-address loads and reset of lsq_dcache_arbiter.
`timescale 1ns/1ps
module tb_lsq_dcache_arbiter;
  localparam int NUM_SUPER    = 2;
  localparam int CSB_DEPTH    = 4;
  localparam int STARVE_LIMIT = 4;
  localparam int ADDR_W       = 61;
  localparam int LQ_IDX_W     = 3;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  lsq_dcache_arbiter_if #(.NUM_SUPER(NUM_SUPER), .ADDR_W(ADDR_W), .LQ_IDX_W(LQ_IDX_W)) bus ();

  lsq_dcache_arbiter #(
    .NUM_SUPER(NUM_SUPER), .CSB_DEPTH(CSB_DEPTH), .STARVE_LIMIT(STARVE_LIMIT),
    .ADDR_W(ADDR_W), .LQ_IDX_W(LQ_IDX_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic retire(input logic [1:0] en,
                        input logic [ADDR_W-1:0] a0, input logic [63:0] v0,
                        input logic [ADDR_W-1:0] a1, input logic [63:0] v1);
    bus.st_wr_en    = en;
    bus.st_addr[0]  = a0;
    bus.st_value[0] = v0;
    bus.st_addr[1]  = a1;
    bus.st_value[1] = v1;
  endtask

  task automatic load(input logic vld, input logic [ADDR_W-1:0] a, input logic [LQ_IDX_W-1:0] t);
    bus.ld_req_valid  = vld;
    bus.ld_req_addr   = a;
    bus.ld_req_lq_idx = t;
  endtask

  initial begin
    retire(2'b00, '0, '0, '0, '0);
    load(1'b0, '0, '0);
    bus.rollback_en  = 1'b0;
    bus.dc_req_ready = 1'b0;
    bus.dc_rsp_valid = 1'b0;
    bus.dc_rsp_data  = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    check_eq("rst_csb_ready", bus.csb_ready, 1);
    check_eq("rst_csb_empty", bus.csb_empty, 1);
    check_eq("rst_dc_req_valid", bus.dc_req_valid, 0);
    check_eq("rst_ld_req_ready", bus.ld_req_ready, 0);
    check_eq("rst_ld_rsp_valid", bus.ld_rsp_valid, 0);
    check_eq("rst_dc_req_addr", bus.dc_req_addr, 0);
    check_eq("rst_ld_rsp_data", bus.ld_rsp_data, 0);
    check_eq("rst_state", dut.state, 0);

    // Two stores drain back to back
    bus.dc_req_ready = 1'b1;
    retire(2'b11, 'h10, 'hAA, 'h20, 'hBB);
    settle();
    check_eq("drain_not_early", bus.dc_req_valid, 0);
    tick();
    retire(2'b00, '0, '0, '0, '0);
    settle();
    check_eq("drain0_valid", bus.dc_req_valid, 1);
    check_eq("drain0_wr", bus.dc_req_wr, 1);
    check_eq("drain0_addr", bus.dc_req_addr, 'h10);
    check_eq("drain0_value", bus.dc_req_value, 'hAA);
    check_eq("drain0_not_empty", bus.csb_empty, 0);
    tick();
    settle();
    check_eq("drain1_addr", bus.dc_req_addr, 'h20);
    check_eq("drain1_value", bus.dc_req_value, 'hBB);
    tick();
    settle();
    check_eq("drain_empty", bus.csb_empty, 1);
    check_eq("drain_idle", bus.dc_req_valid, 0);

    // Fill to full, ignored retire, csb_ready recovers at two free entries
    bus.dc_req_ready = 1'b0;
    retire(2'b11, 'h40, 'h1, 'h41, 'h2);
    tick();
    retire(2'b11, 'h42, 'h3, 'h43, 'h4);
    settle();
    check_eq("fill_ready_half", bus.csb_ready, 1);
    tick();
    retire(2'b11, 'h50, 'h5, 'h51, 'h6);
    settle();
    check_eq("fill_ready_full", bus.csb_ready, 0);
    tick();
    retire(2'b00, '0, '0, '0, '0);
    settle();
    check_eq("fill_count_ignored", dut.count, 4);
    check_eq("fill_full_store_wins", bus.dc_req_wr, 1);
    check_eq("fill_head_addr", bus.dc_req_addr, 'h40);
    bus.dc_req_ready = 1'b1;
    tick();
    settle();
    check_eq("fill_ready_one_free", bus.csb_ready, 0);
    check_eq("fill_addr1", bus.dc_req_addr, 'h41);
    tick();
    settle();
    check_eq("fill_ready_two_free", bus.csb_ready, 1);
    check_eq("fill_addr2", bus.dc_req_addr, 'h42);
    tick();
    settle();
    check_eq("fill_addr3", bus.dc_req_addr, 'h43);
    tick();
    settle();
    check_eq("fill_drained", bus.csb_empty, 1);

    // Store handshake plus dual enqueue at count=2 (head=2, tail=2 here)
    bus.dc_req_ready = 1'b0;
    retire(2'b11, 'h60, 'h6, 'h61, 'h7);
    tick();
    retire(2'b11, 'h62, 'h8, 'h63, 'h9);
    bus.dc_req_ready = 1'b1;
    settle();
    check_eq("dual_addr0", bus.dc_req_addr, 'h60);
    tick();
    retire(2'b00, '0, '0, '0, '0);
    bus.dc_req_ready = 1'b0;
    settle();
    check_eq("dual_count", dut.count, 3);
    check_eq("dual_head", dut.head, 3);
    check_eq("dual_tail", dut.tail, 2);
    check_eq("dual_addr1", bus.dc_req_addr, 'h61);
    bus.dc_req_ready = 1'b1;
    tick();
    settle();
    check_eq("dual_addr2", bus.dc_req_addr, 'h62);
    tick();
    settle();
    check_eq("dual_addr3", bus.dc_req_addr, 'h63);
    tick();
    settle();
    check_eq("dual_empty", bus.csb_empty, 1);

    // Starvation: load wins until starve_cnt reaches the limit
    bus.dc_req_ready = 1'b0;
    retire(2'b01, 'h70, 'h77, '0, '0);
    tick();
    retire(2'b00, '0, '0, '0, '0);
    load(1'b1, 'h99, 3'd1);
    for (int k = 0; k < STARVE_LIMIT; k++) begin
      settle();
      check_eq("starve_cnt_ramp", dut.starve_cnt, k);
      check_eq("starve_load_wins", bus.dc_req_wr, 0);
      check_eq("starve_load_addr", bus.dc_req_addr, 'h99);
      tick();
    end
    settle();
    check_eq("starve_cnt_limit", dut.starve_cnt, 4);
    check_eq("starve_store_wins", bus.dc_req_wr, 1);
    check_eq("starve_store_addr", bus.dc_req_addr, 'h70);
    bus.dc_req_ready = 1'b1;
    settle();
    check_eq("starve_ld_blocked", bus.ld_req_ready, 0);
    tick();
    settle();
    check_eq("starve_cnt_clear", dut.starve_cnt, 0);
    check_eq("starve_empty", bus.csb_empty, 1);
    check_eq("starve_load_next", bus.ld_req_ready, 1);
    tick();
    load(1'b0, '0, '0);
    settle();
    check_eq("starve_ld_wait", dut.state, 1);
    bus.dc_rsp_valid = 1'b1;
    bus.dc_rsp_data  = 64'h1234;
    settle();
    check_eq("starve_rsp_valid", bus.ld_rsp_valid, 1);
    check_eq("starve_rsp_tag", bus.ld_rsp_lq_idx, 1);
    check_eq("starve_rsp_data", bus.ld_rsp_data, 64'h1234);
    tick();
    settle();
    check_eq("starve_back_idle", dut.state, 0);
    check_eq("idle_rsp_ignored", bus.ld_rsp_valid, 0);
    bus.dc_rsp_valid = 1'b0;

    // Rollback squashes an outstanding load
    load(1'b1, 'h80, 3'd5);
    settle();
    check_eq("sq_accept", bus.ld_req_ready, 1);
    tick();
    load(1'b0, '0, '0);
    bus.rollback_en = 1'b1;
    tick();
    bus.rollback_en = 1'b0;
    load(1'b1, 'h88, 3'd6);
    settle();
    check_eq("sq_state", dut.state, 2);
    check_eq("sq_no_new_load", bus.ld_req_ready, 0);
    bus.dc_rsp_valid = 1'b1;
    bus.dc_rsp_data  = 64'hDEAD;
    settle();
    check_eq("sq_rsp_dropped", bus.ld_rsp_valid, 0);
    tick();
    bus.dc_rsp_valid = 1'b0;
    settle();
    check_eq("sq_idle", dut.state, 0);
    check_eq("sq_next_accept", bus.ld_req_ready, 1);
    tick();
    load(1'b0, '0, '0);
    bus.dc_rsp_valid = 1'b1;
    bus.dc_rsp_data  = 64'hBEEF;
    settle();
    check_eq("sq_next_rsp_valid", bus.ld_rsp_valid, 1);
    check_eq("sq_next_rsp_tag", bus.ld_rsp_lq_idx, 6);
    check_eq("sq_next_rsp_data", bus.ld_rsp_data, 64'hBEEF);
    tick();
    bus.dc_rsp_valid = 1'b0;

    // Load to an address held twice in the CSB
    bus.dc_req_ready = 1'b0;
    retire(2'b11, 'h30, 'h11, 'h30, 'h22);
    tick();
    retire(2'b00, '0, '0, '0, '0);
    load(1'b1, 'h30, 3'd3);
    settle();
`ifdef LSQ_ARB_FWD_EN
    check_eq("fwd_accept", bus.ld_req_ready, 1);
    check_eq("fwd_store_drains", bus.dc_req_wr, 1);
    tick();
    load(1'b0, '0, '0);
    settle();
    check_eq("fwd_state", dut.state, 3);
    check_eq("fwd_rsp_valid", bus.ld_rsp_valid, 1);
    check_eq("fwd_rsp_data", bus.ld_rsp_data, 'h22);
    check_eq("fwd_rsp_tag", bus.ld_rsp_lq_idx, 3);
    check_eq("fwd_no_dc_load", bus.dc_req_wr, 1);
    tick();
    bus.dc_req_ready = 1'b1;
    tick();
    tick();
    settle();
    check_eq("fwd_drained", bus.csb_empty, 1);
`else
    check_eq("hold_not_ready", bus.ld_req_ready, 0);
    check_eq("hold_store_wins", bus.dc_req_wr, 1);
    check_eq("hold_value0", bus.dc_req_value, 'h11);
    bus.dc_req_ready = 1'b1;
    settle();
    check_eq("hold_not_ready_dc", bus.ld_req_ready, 0);
    tick();
    settle();
    check_eq("hold_still_blocked", bus.ld_req_ready, 0);
    check_eq("hold_value1", bus.dc_req_value, 'h22);
    tick();
    settle();
    check_eq("hold_released", bus.ld_req_ready, 1);
    check_eq("hold_dc_read", bus.dc_req_wr, 0);
    check_eq("hold_read_addr", bus.dc_req_addr, 'h30);
    tick();
    load(1'b0, '0, '0);
    bus.dc_rsp_valid = 1'b1;
    bus.dc_rsp_data  = 64'h5555;
    settle();
    check_eq("hold_rsp_tag", bus.ld_rsp_lq_idx, 3);
    check_eq("hold_rsp_data", bus.ld_rsp_data, 64'h5555);
    tick();
    bus.dc_rsp_valid = 1'b0;
`endif

    // Reset with stores buffered and a load outstanding
    bus.dc_req_ready = 1'b0;
    retire(2'b11, 'hA0, 'h1, 'hA1, 'h2);
    tick();
    retire(2'b00, '0, '0, '0, '0);
    load(1'b1, 'hB0, 3'd2);
    bus.dc_req_ready = 1'b1;
    tick();
    load(1'b0, '0, '0);
    bus.dc_req_ready = 1'b0;
    settle();
    check_eq("mid_ld_wait", dut.state, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check_eq("mid_rst_empty", bus.csb_empty, 1);
    check_eq("mid_rst_ready", bus.csb_ready, 1);
    check_eq("mid_rst_state", dut.state, 0);
    check_eq("mid_rst_no_req", bus.dc_req_valid, 0);
    bus.dc_rsp_valid = 1'b1;
    settle();
    check_eq("mid_rst_rsp_dropped", bus.ld_rsp_valid, 0);
    bus.dc_rsp_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsq_dcache_arbiter.md
# lsq_dcache_arbiter

Shares the single D-cache port between committed stores leaving the store queue at retire and load requests issued by the load queue. Retired stores are absorbed into a small committed-store buffer (CSB) and drained in order. Loads normally have priority; a starvation counter guarantees the buffer drains. The block tracks one outstanding load, returns its data tagged with the LQ index, and squashes it on rollback.

## Interface
Parameters:
- NUM_SUPER, 2, store retire slots per cycle
- CSB_DEPTH, 4, committed-store buffer entries (power of 2, ≥ NUM_SUPER)
- STARVE_LIMIT, 4, consecutive lost-arbitration cycles before stores win
- ADDR_W, 61, quadword address width
- LQ_IDX_W, 3, LQ index width

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- st_wr_en  in  NUM_SUPER  retiring store valid per slot; slot 0 older
- st_addr  in  NUM_SUPER×ADDR_W  store quadword address
- st_value  in  NUM_SUPER×64  store data
- csb_ready  out  1  at least NUM_SUPER free CSB entries (registered)
- csb_empty  out  1  CSB holds no entries (registered)
- ld_req_valid  in  1  load request
- ld_req_addr  in  ADDR_W  load quadword address
- ld_req_lq_idx  in  LQ_IDX_W  load tag
- ld_req_ready  out  1  load accepted this cycle
- rollback_en  in  1  squash any outstanding load
- dc_req_valid  out  1  D-cache request
- dc_req_wr  out  1  1 = store, 0 = load
- dc_req_addr  out  ADDR_W  request address
- dc_req_value  out  64  store data
- dc_req_ready  in  1  D-cache accepts request
- dc_rsp_valid  in  1  load data return
- dc_rsp_data  in  64  load data
- ld_rsp_valid  out  1  load data to LQ
- ld_rsp_lq_idx  out  LQ_IDX_W  tag of returned load
- ld_rsp_data  out  64  returned data

## Operation
- CSB is a circular FIFO with head, tail, and a count of width log2(CSB_DEPTH)+1. Enqueue: each set st_wr_en slot, in slot order, when csb_ready=1. st_wr_en is ignored while csb_ready=0. Dequeue: the head entry on a store handshake (dc_req_valid & dc_req_wr & dc_req_ready). count_next = count + enqueued − dequeued. Head and tail wrap modulo CSB_DEPTH.
- FSM states:
  - IDLE: no load outstanding.
  - LD_WAIT: load issued to the D-cache.
  - LD_SQUASH: load squashed; its response is still due.
  - LD_FWD: forwarded data is being returned.
- Transitions:
  - IDLE→LD_WAIT on a load handshake to the D-cache.
  - IDLE→LD_FWD on a forwarded load (see Configuration).
  - LD_WAIT→IDLE on dc_rsp_valid.
  - LD_WAIT→LD_SQUASH on rollback_en without dc_rsp_valid.
  - LD_SQUASH→IDLE on dc_rsp_valid; the response is dropped.
  - LD_FWD→IDLE unconditionally, or squashed with no output if rollback_en.
- Arbitration, evaluated combinationally each cycle:
  - The load is eligible only in IDLE, with ld_req_valid and no CSB address conflict.
  - Stores are eligible when the CSB is non-empty.
  - Stores win if the CSB is full, if no load is eligible, or if starve_cnt ≥ STARVE_LIMIT. Otherwise the load wins.
- starve_cnt increments, saturating, each cycle the CSB is non-empty and no store handshake occurs. It clears on a store handshake.
- Stores may issue in any FSM state. dc_req_valid is combinational from the winner.
- ld_req_ready = load won & dc_req_ready, or the forward-accept condition.
- ld_rsp_valid = dc_rsp_valid in LD_WAIT, with data passed through and the registered tag; or asserted in LD_FWD from registers.
- Address conflict check: ld_req_addr against every valid CSB entry. Entries enqueued in the same cycle are not checked, because the SQ still forwards them that cycle.
- rollback_en never discards CSB entries; they are committed.

## Timing
- Reset values:
  - csb_ready=1, csb_empty=1; count, head, tail, starve_cnt = 0; state = IDLE.
  - All valid/ready outputs are 0; data outputs are 0.
- Load latency:
  - D-cache path: ld_rsp follows dc_rsp_valid in the same cycle, whatever the D-cache latency.
  - Forward path: ld_rsp arrives exactly 1 cycle after ld_req_ready.
- Entries enqueued in cycle N are visible to the drain and the conflict check in cycle N+1. csb_ready and csb_empty update in cycle N+1.
- A dc_rsp_valid in IDLE or LD_FWD is ignored.
- Reset mid-operation discards the CSB and any outstanding load.

## Configuration
- LSQ_ARB_FWD_EN defined: a load whose address matches CSB entries accepts in IDLE without a D-cache access, even when dc_req_ready=0. It takes the value of the youngest matching entry and enters LD_FWD. A store may still drain in the same cycle.
- LSQ_ARB_FWD_EN undefined: a matching load is held off (ld_req_ready=0) until all matching entries have drained. LD_FWD is unreachable.

## Test plan
- Reset, then retire 2 stores (addr 0x10 value 0xAA, addr 0x20 value 0xBB), dc_req_ready=1, no loads -> D-cache writes 0x10/0xAA then 0x20/0xBB on consecutive cycles; csb_empty=1 after the second write.
- Fill the CSB to 4 entries -> csb_ready=0; st_wr_en is ignored; one drain restores csb_ready only once ≥2 entries are free.
- CSB holds 1 store and ld_req_valid is held continuously at a non-matching address -> loads win until starve_cnt=4, then the store issues and starve_cnt clears.
- Load tag 5 issued, rollback_en pulsed before dc_rsp_valid -> state LD_SQUASH; the response is dropped with ld_rsp_valid=0; the next load is accepted afterwards.
- CSB holds 0x30/0x11 then 0x30/0x22; load addr 0x30 tag 3:
  - with LSQ_ARB_FWD_EN -> ld_rsp next cycle, data 0x22, tag 3, no D-cache load.
  - without it -> ld_req_ready=0 until both stores drain, then a D-cache read.
- Store handshake and dual enqueue in the same cycle at count=2 -> count=3, tail advances by 2, head by 1.
